tile_fetch_engine: RTL and testbench

TILE_FETCH_ENGINE -- requirements
Module: tile_fetch_engine

---
 rtl/tile_fetch_engine_pkg.sv | 22 ++
 rtl/tile_fetch_engine_rd_tag_pipe.sv | 55 +++++
 rtl/tile_fetch_engine.sv | 189 ++++++++++++++++++
 tb/tb_tile_fetch_engine.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_fetch_engine_pkg.sv
// Shared types and default sizes for the tile fetch engine.
// Holds the FSM state encoding and a width helper.
package tile_fetch_engine_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_TILE   = 4;
    localparam int DEF_DIM_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_fetch_engine_rd_tag_pipe.sv
// Read tag pipeline: carries valid + element index alongside
// outstanding memory reads so returning data finds its slot.
module rd_tag_pipe #(
    parameter int MEM_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             pend
);

    logic [MEM_LAT-1:0] vld_q;
    logic [MEM_LAT-1:0] vld_d;
    logic [TAG_W-1:0]   tag_q [MEM_LAT];
    logic [TAG_W-1:0]   tag_d [MEM_LAT];

    // Shift the tag one stage per cycle.
    always_comb begin
        vld_d    = '0;
        tag_d    = '{default: '0};
        vld_d[0] = in_valid;
        tag_d[0] = in_tag;
        for (int k = 1; k < MEM_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            tag_d[k] = tag_q[k-1];
        end
    end

    // Stage registers; reset flushes every in-flight tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            tag_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    // Tags still in flight after the oldest one retires.
    always_comb begin
        pend = 1'b0;
        for (int k = 0; k < MEM_LAT - 1; k++) begin
            pend = pend | vld_q[k];
        end
    end

    assign out_valid = vld_q[MEM_LAT-1];
    assign out_tag   = tag_q[MEM_LAT-1];

endmodule

// File: rtl/tile_fetch_engine.sv
// Fetches a TILE x TILE window of a row-major matrix from memory,
// zero-filling elements that fall outside the matrix edges.
import tile_fetch_engine_pkg::*;

module tile_fetch_engine #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TILE    = DEF_TILE,
    parameter int DIM_W   = DEF_DIM_W,
    parameter int MEM_LAT = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_base,
    input  logic [DIM_W-1:0]            cmd_rows,
    input  logic [DIM_W-1:0]            cmd_cols,
    input  logic [DIM_W-1:0]            cmd_row_idx,
    input  logic [DIM_W-1:0]            cmd_col_idx,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        tile_valid,
    input  logic                        tile_ready,
    output logic [TILE*TILE*DATA_W-1:0] tile_data,
    output logic                        busy,
    output logic                        err
);

    localparam int N     = TILE * TILE;
    localparam int IDX_W = clog2_min1(N);
    localparam int TW    = clog2_min1(TILE);
    localparam int TD_W  = N * DATA_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic [DIM_W-1:0]    cols_q, cols_d;
    logic [TW-1:0]       last_i_q, last_i_d;
    logic [TW-1:0]       last_j_q, last_j_d;
    logic [TW-1:0]       i_q, i_d;
    logic [TW-1:0]       j_q, j_d;
    logic                err_q, err_d;
    logic [TD_W-1:0]     buf_q, buf_d;

    logic                bad_cmd;
    logic                accept;
    logic [DIM_W-1:0]    rem_r;
    logic [DIM_W-1:0]    rem_c;
    logic [IDX_W-1:0]    rd_idx;
    logic                ret_valid;
    logic [IDX_W-1:0]    ret_idx;
    logic                ret_pend;

    // Command screening and the in-bounds extent of the window.
    // The in-bounds set is a rectangle, so only its size matters.
    always_comb begin
        bad_cmd = (cmd_rows == '0) || (cmd_cols == '0) ||
                  (cmd_row_idx >= cmd_rows) ||
                  (cmd_col_idx >= cmd_cols);
        rem_r   = cmd_rows - cmd_row_idx;
        rem_c   = cmd_cols - cmd_col_idx;
        rd_idx  = IDX_W'(32'(i_q) * TILE + 32'(j_q));
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        cols_d     = cols_q;
        last_i_d   = last_i_q;
        last_j_d   = last_j_q;
        i_d        = i_q;
        j_d        = j_q;
        err_d      = 1'b0;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        tile_valid = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (bad_cmd) begin
                        err_d = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_d    = ST_FETCH;
                        cols_d     = cmd_cols;
                        i_d        = '0;
                        j_d        = '0;
                        row_addr_d = cmd_base
                                   + ADDR_W'(cmd_row_idx)
                                   * ADDR_W'(cmd_cols)
                                   + ADDR_W'(cmd_col_idx);
                        last_i_d   = (32'(rem_r) >= TILE)
                                   ? TW'(TILE - 1)
                                   : TW'(rem_r - 1'b1);
                        last_j_d   = (32'(rem_c) >= TILE)
                                   ? TW'(TILE - 1)
                                   : TW'(rem_c - 1'b1);
                    end
                end
            end
            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = row_addr_q + ADDR_W'(j_q);
                if (j_q == last_j_q) begin
                    j_d = '0;
                    if (i_q == last_i_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        i_d        = i_q + 1'b1;
                        row_addr_d = row_addr_q + ADDR_W'(cols_q);
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!ret_pend) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                tile_valid = 1'b1;
                if (tile_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tile buffer: cleared on accept, filled by returning reads.
    always_comb begin
        buf_d = buf_q;
        if (accept) begin
            buf_d = '0;
        end
        if (ret_valid) begin
            buf_d[32'(ret_idx) * DATA_W +: DATA_W] = mem_rdata;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_addr_q <= '0;
            cols_q     <= '0;
            last_i_q   <= '0;
            last_j_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            err_q      <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_addr_q <= row_addr_d;
            cols_q     <= cols_d;
            last_i_q   <= last_i_d;
            last_j_q   <= last_j_d;
            i_q        <= i_d;
            j_q        <= j_d;
            err_q      <= err_d;
            buf_q      <= buf_d;
        end
    end

    rd_tag_pipe #(
        .MEM_LAT (MEM_LAT),
        .TAG_W   (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mem_rd),
        .in_tag    (rd_idx),
        .out_valid (ret_valid),
        .out_tag   (ret_idx),
        .pend      (ret_pend)
    );

    assign tile_data = buf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tile_fetch_engine.sv
// Bench for tile_fetch_engine: two instances (latency 1 and 3)
// driven with the same commands, checked against a window model.
module tb_tile_fetch_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int TILE   = 4;
    localparam int DIM_W  = 8;
    localparam int TD     = TILE * TILE * DATA_W;
    localparam int MSIZE  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_base;
    logic [DIM_W-1:0]  cmd_rows, cmd_cols;
    logic [DIM_W-1:0]  cmd_row_idx, cmd_col_idx;
    logic              tile_ready;

    logic              cmd_ready1, mem_rd1, tile_valid1, busy1, err1;
    logic [ADDR_W-1:0] mem_addr1;
    logic [DATA_W-1:0] mem_rdata1;
    logic [TD-1:0]     tile_data1;

    logic              cmd_ready3, mem_rd3, tile_valid3, busy3, err3;
    logic [ADDR_W-1:0] mem_addr3;
    logic [DATA_W-1:0] mem_rdata3;
    logic [TD-1:0]     tile_data3;

    logic [DATA_W-1:0] mem [MSIZE];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_fetch_engine #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_base(cmd_base), .cmd_rows(cmd_rows),
        .cmd_cols(cmd_cols), .cmd_row_idx(cmd_row_idx),
        .cmd_col_idx(cmd_col_idx),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1),
        .tile_valid(tile_valid1), .tile_ready(tile_ready),
        .tile_data(tile_data1), .busy(busy1), .err(err1)
    );

    tile_fetch_engine #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
        .cmd_base(cmd_base), .cmd_rows(cmd_rows),
        .cmd_cols(cmd_cols), .cmd_row_idx(cmd_row_idx),
        .cmd_col_idx(cmd_col_idx),
        .mem_rd(mem_rd3), .mem_addr(mem_addr3),
        .mem_rdata(mem_rdata3),
        .tile_valid(tile_valid3), .tile_ready(tile_ready),
        .tile_data(tile_data3), .busy(busy3), .err(err3)
    );

    // Memory models: fixed-latency read ports, not reset.
    logic              pv1;
    logic [ADDR_W-1:0] pa1;
    logic              pv3 [3];
    logic [ADDR_W-1:0] pa3 [3];

    always @(posedge clk) begin
        pv1    <= mem_rd1;
        pa1    <= mem_addr1;
        pv3[0] <= mem_rd3;
        pa3[0] <= mem_addr3;
        pv3[1] <= pv3[0];
        pa3[1] <= pa3[0];
        pv3[2] <= pv3[1];
        pa3[2] <= pa3[1];
    end

    assign mem_rdata1 = (pv1 === 1'b1) ? mem[pa1] : 32'hDEADBEEF;
    assign mem_rdata3 = (pv3[2] === 1'b1) ? mem[pa3[2]] : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [TD-1:0] obs,
                       input logic [TD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready1", cmd_ready1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_rd1", mem_rd1, 0);
        chk("rst_addr1", mem_addr1, 0);
        chk("rst_tv1", tile_valid1, 0);
        chk("rst_err1", err1, 0);
        chk("rst_data1", tile_data1, 0);
        chk("rst_ready3", cmd_ready3, 1);
        chk("rst_busy3", busy3, 0);
        chk("rst_rd3", mem_rd3, 0);
        chk("rst_tv3", tile_valid3, 0);
        chk("rst_data3", tile_data3, 0);
    endtask

    task automatic drive_cmd(input int base, input int rows,
                             input int cols, input int ri,
                             input int ci);
        cmd_valid   = 1'b1;
        cmd_base    = ADDR_W'(base);
        cmd_rows    = DIM_W'(rows);
        cmd_cols    = DIM_W'(cols);
        cmd_row_idx = DIM_W'(ri);
        cmd_col_idx = DIM_W'(ci);
    endtask

    // Issue a legal command and follow both engines cycle by cycle.
    task automatic run_cmd(input int base, input int rows,
                           input int cols, input int ri,
                           input int ci, input int hold);
        logic [TD-1:0] et;
        int            ea[$];
        int            k;
        int            a;
        int            xa;
        et = '0;
        for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
                if (ri + i < rows && ci + j < cols) begin
                    a = (base + (ri + i) * cols + ci + j) % MSIZE;
                    ea.push_back(a);
                    et[(i * TILE + j) * DATA_W +: DATA_W] = mem[a];
                end
            end
        end
        k = ea.size();
        @(negedge clk);
        drive_cmd(base, rows, cols, ri, ci);
        chk("cmd_ready1", cmd_ready1, 1);
        chk("cmd_ready3", cmd_ready3, 1);
        for (int n = 1; n <= k + 4; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
            xa = (n <= k) ? ea[n - 1] : 0;
            chk("rd1", mem_rd1, n <= k);
            chk("addr1", mem_addr1, xa);
            chk("rd3", mem_rd3, n <= k);
            chk("addr3", mem_addr3, xa);
            chk("tv1", tile_valid1, n >= k + 2);
            chk("tv3", tile_valid3, n >= k + 4);
            chk("busy1", busy1, 1);
            chk("busy3", busy3, 1);
            chk("ready1_busy", cmd_ready1, 0);
        end
        chk("data1", tile_data1, et);
        chk("data3", tile_data3, et);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_data1", tile_data1, et);
            chk("hold_data3", tile_data3, et);
            chk("hold_ready1", cmd_ready1, 0);
            chk("hold_tv1", tile_valid1, 1);
        end
        tile_ready = 1'b1;
        @(negedge clk);
        tile_ready = 1'b0;
        chk("done_ready1", cmd_ready1, 1);
        chk("done_ready3", cmd_ready3, 1);
        chk("done_tv1", tile_valid1, 0);
        chk("done_busy3", busy3, 0);
    endtask

    // Issue an illegal command: one err pulse, no reads.
    task automatic reject_cmd(input int base, input int rows,
                              input int cols, input int ri,
                              input int ci);
        @(negedge clk);
        drive_cmd(base, rows, cols, ri, ci);
        chk("rej_ready1", cmd_ready1, 1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
            chk("rej_err1", err1, n == 1);
            chk("rej_err3", err3, n == 1);
            chk("rej_rd1", mem_rd1, 0);
            chk("rej_rd3", mem_rd3, 0);
            chk("rej_ready1", cmd_ready1, 1);
            chk("rej_busy1", busy1, 0);
        end
    endtask

    initial begin
        int rows, cols, ri, ci, base, hold;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_base    = '0;
        cmd_rows    = '0;
        cmd_cols    = '0;
        cmd_row_idx = '0;
        cmd_col_idx = '0;
        tile_ready  = 1'b0;
        for (int a = 0; a < MSIZE; a++) mem[a] = $urandom;

        repeat (3) @(negedge clk);
        chk_reset_outs();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outs();

        run_cmd(16, 8, 8, 4, 4, 0);
        run_cmd(0, 5, 6, 4, 4, 0);
        reject_cmd(0, 8, 8, 8, 0);
        reject_cmd(3, 0, 8, 0, 0);
        reject_cmd(3, 8, 5, 0, 5);
        run_cmd(300, 8, 8, 0, 0, 10);

        // Reset in the middle of a full-tile fetch.
        @(negedge clk);
        drive_cmd(100, 8, 8, 0, 0);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk_reset_outs();
        @(negedge clk);
        reset = 1'b0;
        run_cmd(200, 8, 8, 2, 1, 0);

        run_cmd(500, 20, 20, 2, 3, 1);
        run_cmd(10, 255, 255, 253, 254, 0);

        for (int t = 0; t < 25; t++) begin
            rows = $urandom_range(0, 12);
            cols = $urandom_range(0, 12);
            if (t % 5 == 4) begin
                rows = $urandom_range(200, 254);
                cols = $urandom_range(200, 254);
            end
            ri   = $urandom_range(0, rows + 1);
            ci   = $urandom_range(0, cols + 1);
            base = $urandom_range(0, MSIZE - 1);
            hold = $urandom_range(0, 3);
            if (rows > 0 && cols > 0 && ri < rows && ci < cols)
                run_cmd(base, rows, cols, ri, ci, hold);
            else
                reject_cmd(base, rows, cols, ri, ci);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
